// File: rtl/axi_rd_pkg.sv
// ============================================================================
// Module   : axi_rd_pkg
// Brief    : Shared types and constants for the AXI4 read-slave memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_rd_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_rd_mem.sv
// ============================================================================
// Module   : axi_rd_mem
// Brief    : Word array with one clocked write port and one asynchronous read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_rd_mem #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/axi_read_slave_mem.sv
// ============================================================================
// Module   : axi_read_slave_mem
// Brief    : AXI4 read responder (AR + R) serving INCR bursts from on-chip
//            memory. Define AXI_RD_SLV_RANGE_CHECK_EN to return SLVERR for
//            beats outside the BASE_ADDR window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_read_slave_mem
    import axi_rd_pkg::*;
#(
    parameter int                DATA_W      = AXI_DATA_W,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDR_W-1:0]              ARADDR,
    input  logic [AXI_LEN_W-1:0]           ARLEN,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_W-1:0]              RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic                           RLAST,
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]              ld_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    rd_state_e            r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [AXI_LEN_W-1:0] r_len;
    logic [AXI_LEN_W-1:0] r_beat_cnt;
    logic                 r_arready;
    logic                 r_rvalid;
    logic                 r_rlast;
    logic [DATA_W-1:0]    r_rdata;
    resp_e                r_rresp;

    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic [ADDR_W-1:0]    w_next_addr;
    logic [ADDR_W-1:0]    w_off;
    logic [IDX_W-1:0]     w_next_idx;
    logic [DATA_W-1:0]    w_mem_rdata;
    logic [DATA_W-1:0]    w_fwd_data;
    logic [DATA_W-1:0]    w_next_data;
    resp_e                w_next_resp;
    logic [AXI_LEN_W-1:0] w_cnt_inc;
    logic                 w_unused;

    assign w_ar_hs   = ARVALID && r_arready && (r_state == IDLE);
    assign w_r_hs    = r_rvalid && RREADY;
    assign w_cnt_inc = r_beat_cnt + AXI_LEN_W'(1);

    // Address of the beat about to be loaded into the R registers.
    assign w_next_addr = (r_state == IDLE) ? {ARADDR[ADDR_W-1:2], 2'b00}
                                           : r_addr + ADDR_W'(4);
    assign w_off       = w_next_addr - BASE_ADDR;
    assign w_next_idx  = w_off[IDX_W+1:2];

    axi_rd_mem #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .i_clk     (ACLK),
        .i_we      (ld_we),
        .i_wr_addr (ld_addr),
        .i_wr_data (ld_data),
        .i_rd_addr (w_next_idx),
        .o_rd_data (w_mem_rdata)
    );

    // A load landing on the same edge that captures a beat must be seen by it.
    assign w_fwd_data = (ld_we && (ld_addr == w_next_idx)) ? ld_data : w_mem_rdata;

`ifdef AXI_RD_SLV_RANGE_CHECK_EN
    logic w_in_range;

    assign w_in_range = ({1'b0, w_next_addr} >= {1'b0, BASE_ADDR}) &&
                        ({1'b0, w_next_addr} <  ({1'b0, BASE_ADDR} +
                                                 (ADDR_W+1)'(4 * DEPTH_WORDS)));

    always_comb begin
        w_next_data = '0;
        w_next_resp = SLVERR;
        if (w_in_range) begin
            w_next_data = w_fwd_data;
            w_next_resp = OKAY;
        end
    end
`else
    assign w_next_data = w_fwd_data;
    assign w_next_resp = OKAY;
`endif

    assign w_unused = &{1'b0, ARADDR[1:0], w_off};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_state    <= BURST;
                        r_addr     <= w_next_addr;
                        r_len      <= ARLEN;
                        r_beat_cnt <= '0;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rlast    <= (ARLEN == '0);
                        r_rdata    <= w_next_data;
                        r_rresp    <= w_next_resp;
                    end else begin
                        r_arready  <= 1'b1;
                    end
                end
                BURST: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_state    <= IDLE;
                            r_rvalid   <= 1'b0;
                            r_rlast    <= 1'b0;
                            r_arready  <= 1'b1;
                            r_beat_cnt <= '0;
                        end else begin
                            r_addr     <= w_next_addr;
                            r_beat_cnt <= w_cnt_inc;
                            r_rlast    <= (w_cnt_inc == r_len);
                            r_rdata    <= w_next_data;
                            r_rresp    <= w_next_resp;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b0;
                end
            endcase
        end
    end

    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RLAST   = r_rlast;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

endmodule

`default_nettype wire
